tx_gearbox_66to32: RTL and testbench

- Transmit-side gearbox that packs 66-bit frames (2-bit sync header followed by a 64-bit payload) into a continuous stream of 32-bit words.
- It feeds the serializer at the far end of the link, which the receive-side aligner/seeker tree locks onto.
- When the source has no frame ready at a load point, it inserts an idle frame so the header cadence is never broken.
- It exports a window index that matches the receiver's gbox_cnt convention.

---
 rtl/tx_gearbox_66to32.sv | 130 +++++++++++++
 tb/tb_tx_gearbox_66to32.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tx_gearbox_66to32.sv
// tx_gearbox_66to32 -- transmit gearbox packing 66-bit frames
// ({hdr[1:0], data[63:0]}, hdr[1] first on the wire) into a continuous
// stream of 32-bit words with data_o[31] as the first wire bit.
// An idle frame is inserted whenever no frame is offered at a load point,
// so the header cadence never breaks.
// Optional feature: define TX_GBOX_SLIP_EN to let slip_i discard one bit
// at the buffer head (one bit per enabled slip cycle).
// If a skip or slip leaves fewer than 32 bits after a load, that cycle
// emits nothing and the next cycle loads again, so the stream stays exact.

module tx_gearbox_66to32_chk (
    input logic       clk,
    input logic       rst,
    input logic [6:0] lvl
);
    lvl_range_a: assert property (@(posedge clk) disable iff (rst) lvl <= 7'd97);
endmodule

module tx_gearbox_66to32 #(
    parameter logic [1:0]  IDLE_HDR     = 2'b10,
    parameter logic [63:0] IDLE_PAYLOAD = 64'h1E00_0000_0000_0000,
    parameter int unsigned INIT_SKIP    = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        tx_en_i,
    input  logic [1:0]  frame_hdr_i,
    input  logic [63:0] frame_data_i,
    input  logic        frame_valid_i,
    output logic        frame_ready_o,
    input  logic        slip_i,
    output logic [31:0] data_o,
    output logic        data_valid_o,
    output logic [5:0]  gbox_cnt_o,
    output logic        idle_ins_o
);
    localparam logic [6:0] INIT_SKIP_W = 7'(INIT_SKIP);

    logic [96:0] buf_r;
    logic [6:0]  lvl_r;
    logic [6:0]  skip_r;
    logic [5:0]  word_idx_r;

    logic        load_s;
    logic        slip_amt_s;
    logic [65:0] ins_s;
    logic [96:0] fill_s;
    logic [96:0] work_s;
    logic [96:0] next_buf_s;
    logic [7:0]  avail_s;
    logic [7:0]  drop_s;
    logic [6:0]  next_lvl_s;
    logic        emit_s;

    assign load_s        = (lvl_r < 7'd32);
    assign frame_ready_o = tx_en_i & load_s;
    assign ins_s         = frame_valid_i ? {frame_hdr_i, frame_data_i}
                                         : {IDLE_HDR, IDLE_PAYLOAD};

`ifdef TX_GBOX_SLIP_EN
    assign slip_amt_s = slip_i;
`else
    // slip request is masked off so the stream follows the no-slip schedule
    assign slip_amt_s = slip_i & 1'b0;
`endif

    // Next-state datapath: append a frame, drop skip/slip bits, take one word
    always_comb begin
        fill_s  = buf_r;
        avail_s = {1'b0, lvl_r};
        drop_s  = {7'd0, slip_amt_s};
        if (load_s) begin
            fill_s  = buf_r | ({ins_s, 31'd0} >> lvl_r);
            avail_s = {1'b0, lvl_r} + 8'd66;
            drop_s  = {1'b0, skip_r} + {7'd0, slip_amt_s};
        end else begin
            fill_s  = buf_r;
            avail_s = {1'b0, lvl_r};
        end
        work_s  = fill_s << drop_s;
        avail_s = avail_s - drop_s;
        emit_s  = (avail_s >= 8'd32);
        if (emit_s) begin
            next_buf_s = work_s << 7'd32;
            next_lvl_s = 7'(avail_s - 8'd32);
        end else begin
            next_buf_s = work_s;
            next_lvl_s = avail_s[6:0];
        end
    end

    // Buffer, fill level, skip counter and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_r        <= 97'd0;
            lvl_r        <= 7'd0;
            skip_r       <= INIT_SKIP_W;
            word_idx_r   <= 6'd0;
            data_o       <= 32'd0;
            data_valid_o <= 1'b0;
            gbox_cnt_o   <= 6'd0;
            idle_ins_o   <= 1'b0;
        end else if (tx_en_i) begin
            buf_r      <= next_buf_s;
            lvl_r      <= next_lvl_s;
            idle_ins_o <= load_s & ~frame_valid_i;
            if (load_s) begin
                skip_r <= 7'd0;
            end
            if (emit_s) begin
                data_o       <= work_s[96:65];
                data_valid_o <= 1'b1;
                gbox_cnt_o   <= word_idx_r;
                word_idx_r   <= (word_idx_r == 6'd32) ? 6'd0 : word_idx_r + 6'd1;
            end else begin
                data_valid_o <= 1'b0;
            end
        end else begin
            data_valid_o <= 1'b0;
            idle_ins_o   <= 1'b0;
        end
    end

    tx_gearbox_66to32_chk u_chk (
        .clk (clk_i),
        .rst (rst_i),
        .lvl (lvl_r)
    );

endmodule

// File: tb/tb_tx_gearbox_66to32.sv
// Directed bench for tx_gearbox_66to32: a bit-queue reference model of the
// wire stream plus hand-computed words and header positions.
module tb_tx_gearbox_66to32;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, tx_en, frame_valid, slip;
    logic [1:0]  frame_hdr;
    logic [63:0] frame_data;
    logic        frame_ready, data_valid, idle_ins;
    logic [31:0] data;
    logic [5:0]  gbox_cnt;
    logic        frame_ready5, data_valid5, idle_ins5;
    logic [31:0] data5;
    logic [5:0]  gbox_cnt5;

    tx_gearbox_66to32 dut (
        .clk_i(clk), .rst_i(rst), .tx_en_i(tx_en), .frame_hdr_i(frame_hdr),
        .frame_data_i(frame_data), .frame_valid_i(frame_valid),
        .frame_ready_o(frame_ready), .slip_i(slip), .data_o(data),
        .data_valid_o(data_valid), .gbox_cnt_o(gbox_cnt), .idle_ins_o(idle_ins)
    );

    tx_gearbox_66to32 #(.INIT_SKIP(5)) dut5 (
        .clk_i(clk), .rst_i(rst), .tx_en_i(tx_en), .frame_hdr_i(frame_hdr),
        .frame_data_i(frame_data), .frame_valid_i(frame_valid),
        .frame_ready_o(frame_ready5), .slip_i(slip), .data_o(data5),
        .data_valid_o(data_valid5), .gbox_cnt_o(gbox_cnt5), .idle_ins_o(idle_ins5)
    );

    int n_tests = 0;
    int n_fail  = 0;

    bit q[$];
    bit stream[$];
    bit stream5[$];
    bit cont_stream[$];
    logic [63:0] src_data;
    int          word_idx;
    logic [31:0] exp_data;
    logic [5:0]  exp_cnt;
    logic        exp_valid, exp_ready, exp_idle, obs_ready;

    task automatic push_frame(input logic [65:0] f);
        for (int j = 65; j >= 0; j--) q.push_back(f[j]);
    endtask

    // one clock of stimulus plus the reference-model update; no checking here
    task automatic cycle(input logic en, input logic vld, input logic slp);
        tx_en = en; frame_valid = vld; frame_hdr = 2'b01; frame_data = src_data; slip = slp;
        #1;
        obs_ready = frame_ready;
        exp_ready = en && (q.size() < 32);
        exp_idle  = 1'b0;
        exp_valid = 1'b0;
        if (en) begin
            if (q.size() < 32) begin
                if (vld) begin
                    push_frame({2'b01, src_data});
                    src_data = src_data + 64'd1;
                end else begin
                    push_frame({2'b10, 64'h1E00_0000_0000_0000});
                    exp_idle = 1'b1;
                end
            end
`ifdef TX_GBOX_SLIP_EN
            if (slp) void'(q.pop_front());
`endif
            if (q.size() >= 32) begin
                for (int j = 31; j >= 0; j--) exp_data[j] = q.pop_front();
                exp_valid = 1'b1;
                exp_cnt   = 6'(word_idx);
                word_idx  = (word_idx == 32) ? 0 : word_idx + 1;
            end
        end
        @(posedge clk); #1;
        if (data_valid)  for (int j = 31; j >= 0; j--) stream.push_back(data[j]);
        if (data_valid5) for (int j = 31; j >= 0; j--) stream5.push_back(data5[j]);
    endtask

    task automatic do_reset(input logic en);
        rst = 1'b1; tx_en = en; frame_valid = 1'b0; slip = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete(); stream.delete(); stream5.delete();
        word_idx = 0; src_data = 64'd0; exp_data = 32'd0; exp_cnt = 6'd0;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        n_tests++; if (data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 00000000", data); end
        n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", data_valid); end
        n_tests++; if (gbox_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", gbox_cnt); end
        n_tests++; if (idle_ins !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got %b expected 0", idle_ins); end
        n_tests++; if (frame_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_dis: got %b expected 0", frame_ready); end
        tx_en = 1'b1; #1;
        n_tests++; if (frame_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_en: got %b expected 1", frame_ready); end
        tx_en = 1'b0;
    endtask

    task automatic test_continuous();
        int rdy_cnt;
        int bad_hdr;
        rdy_cnt = 0; bad_hdr = 0;
        do_reset(1'b0);
        for (int i = 0; i < 66; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            if (i < 33 && obs_ready) rdy_cnt++;
            n_tests++; if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL cont_ready[%0d]: got %b expected %b", i, obs_ready, exp_ready); end
            n_tests++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL cont_valid[%0d]: got %b expected 1", i, data_valid); end
            n_tests++; if (data !== exp_data) begin n_fail++; $display("FAIL cont_data[%0d]: got %h expected %h", i, data, exp_data); end
            n_tests++; if (gbox_cnt !== exp_cnt) begin n_fail++; $display("FAIL cont_cnt[%0d]: got %0d expected %0d", i, gbox_cnt, exp_cnt); end
            if (i == 0) begin n_tests++; if (data !== 32'h4000_0000) begin n_fail++; $display("FAIL cont_word0: got %h expected 40000000", data); end end
            if (i == 1) begin n_tests++; if (data !== 32'h0000_0000) begin n_fail++; $display("FAIL cont_word1: got %h expected 00000000", data); end end
            if (i == 2) begin n_tests++; if (data !== 32'h1000_0000) begin n_fail++; $display("FAIL cont_word2: got %h expected 10000000", data); end end
            if (i == 32) begin n_tests++; if (gbox_cnt !== 6'd32) begin n_fail++; $display("FAIL cont_cnt32: got %0d expected 32", gbox_cnt); end end
            if (i == 33) begin n_tests++; if (gbox_cnt !== 6'd0) begin n_fail++; $display("FAIL cont_wrap: got %0d expected 0", gbox_cnt); end end
        end
        n_tests++; if (rdy_cnt != 16) begin n_fail++; $display("FAIL cont_ready_count: got %0d expected 16", rdy_cnt); end
        n_tests++;
        if (stream.size() != 2112) begin
            n_fail++; $display("FAIL cont_stream_len: got %0d expected 2112", stream.size());
        end else begin
            for (int k = 0; k < 32; k++)
                if (stream[66*k] != 1'b0 || stream[66*k+1] != 1'b1) bad_hdr++;
            n_tests++; if (bad_hdr != 0) begin n_fail++; $display("FAIL cont_hdr_pos: got %0d bad headers expected 0", bad_hdr); end
        end
        cont_stream = stream;
    endtask

    task automatic test_idle();
        int pulses;
        pulses = 0;
        do_reset(1'b0);
        for (int i = 0; i < 33; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            if (idle_ins) pulses++;
            n_tests++; if (data !== exp_data) begin n_fail++; $display("FAIL idle_data[%0d]: got %h expected %h", i, data, exp_data); end
            n_tests++; if (idle_ins !== exp_idle) begin n_fail++; $display("FAIL idle_pulse[%0d]: got %b expected %b", i, idle_ins, exp_idle); end
            if (i == 0) begin n_tests++; if (data !== 32'h8780_0000) begin n_fail++; $display("FAIL idle_word0: got %h expected 87800000", data); end end
        end
        n_tests++; if (pulses != 16) begin n_fail++; $display("FAIL idle_count: got %0d expected 16", pulses); end
    endtask

    task automatic test_toggle();
        int diff;
        diff = 0;
        do_reset(1'b0);
        for (int i = 0; i < 80; i++) begin
            cycle((i % 2) == 0, 1'b1, 1'b0);
            n_tests++; if (data_valid !== exp_valid) begin n_fail++; $display("FAIL tog_valid[%0d]: got %b expected %b", i, data_valid, exp_valid); end
            n_tests++; if (data !== exp_data) begin n_fail++; $display("FAIL tog_data[%0d]: got %h expected %h", i, data, exp_data); end
            n_tests++; if (gbox_cnt !== exp_cnt) begin n_fail++; $display("FAIL tog_cnt[%0d]: got %0d expected %0d", i, gbox_cnt, exp_cnt); end
            n_tests++; if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL tog_ready[%0d]: got %b expected %b", i, obs_ready, exp_ready); end
        end
        for (int k = 0; k < 1280; k++)
            if (k >= stream.size() || stream[k] != cont_stream[k]) diff++;
        n_tests++; if (diff != 0) begin n_fail++; $display("FAIL tog_vs_cont: got %0d differing bits expected 0", diff); end
    endtask

    task automatic test_slip();
        int diff;
        diff = 0;
        do_reset(1'b0);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b1, i == 10);
            n_tests++; if (data_valid !== exp_valid) begin n_fail++; $display("FAIL slip_valid[%0d]: got %b expected %b", i, data_valid, exp_valid); end
            n_tests++; if (data !== exp_data) begin n_fail++; $display("FAIL slip_data[%0d]: got %h expected %h", i, data, exp_data); end
        end
`ifndef TX_GBOX_SLIP_EN
        for (int k = 0; k < 1280; k++)
            if (k >= stream.size() || stream[k] != cont_stream[k]) diff++;
        n_tests++; if (diff != 0) begin n_fail++; $display("FAIL slip_ignored: got %0d differing bits expected 0", diff); end
`endif
    endtask

    task automatic test_init_skip();
        logic [31:0] w0, w1;
        int bad_hdr;
        bad_hdr = 0;
        do_reset(1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b0);
        n_tests++;
        if (stream5.size() < 640) begin
            n_fail++; $display("FAIL skip_len: got %0d expected >= 640", stream5.size());
        end else begin
            for (int j = 0; j < 32; j++) begin
                w0[31-j] = stream5[j];
                w1[31-j] = stream5[32+j];
            end
            n_tests++; if (w0 !== 32'h0000_0000) begin n_fail++; $display("FAIL skip_word0: got %h expected 00000000", w0); end
            n_tests++; if (w1 !== 32'h0000_0002) begin n_fail++; $display("FAIL skip_word1: got %h expected 00000002", w1); end
            for (int k = 0; k < 9; k++)
                if (stream5[61+66*k] != 1'b0 || stream5[62+66*k] != 1'b1) bad_hdr++;
            n_tests++; if (bad_hdr != 0) begin n_fail++; $display("FAIL skip_hdr_pos: got %0d bad headers expected 0", bad_hdr); end
        end
    endtask

    task automatic test_reset_midstream();
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0);
        rst = 1'b1; tx_en = 1'b1; frame_valid = 1'b1; frame_data = src_data;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete(); word_idx = 0;
        n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b expected 0", data_valid); end
        n_tests++; if (gbox_cnt !== 6'd0) begin n_fail++; $display("FAIL mid_cnt: got %0d expected 0", gbox_cnt); end
        n_tests++; if (frame_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b expected 1", frame_ready); end
        cycle(1'b1, 1'b1, 1'b0);
        n_tests++; if (data !== 32'h4000_0000) begin n_fail++; $display("FAIL mid_word0: got %h expected 40000000", data); end
        n_tests++; if (gbox_cnt !== 6'd0) begin n_fail++; $display("FAIL mid_cnt0: got %0d expected 0", gbox_cnt); end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            n_tests++; if (data !== exp_data) begin n_fail++; $display("FAIL mid_data[%0d]: got %h expected %h", i, data, exp_data); end
            n_tests++; if (gbox_cnt !== exp_cnt) begin n_fail++; $display("FAIL mid_cnt[%0d]: got %0d expected %0d", i, gbox_cnt, exp_cnt); end
        end
    endtask

    initial begin
        rst = 1'b1; tx_en = 1'b0; frame_valid = 1'b0; slip = 1'b0;
        frame_hdr = 2'b00; frame_data = 64'd0; src_data = 64'd0;
        word_idx = 0; exp_data = 32'd0; exp_cnt = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_continuous();
        test_idle();
        test_toggle();
        test_slip();
        test_init_skip();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
